step_pulse_gen: RTL and testbench

//  Stepper-motor pulse generator downstream of the tracking controller. Consumes the period word N,

---
 rtl/step_pulse_gen.sv | 177 +++++++++++++++++
 tb/tb_step_pulse_gen.sv | 310 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/step_pulse_gen.sv
// step_pulse_gen: stepper motor STEP/DIR/ENABLE driver.
// Clamped glitch-free period, DIR setup, fixed pulse width, position.
//
// Ports:
//   clk        system clock
//   rst        asynchronous active-low reset
//   enable     tracking enable (clk domain)
//   dir        requested direction (clk domain)
//   N          step period in ticks (asynchronous to clk)
//   drv_step   STEP pin
//   drv_dir    DIR pin
//   drv_enable driver enable pin, active-high
//   busy       high whenever the FSM is not idle
//   position   signed step count, two's complement
module step_pulse_gen #(
    parameter int WIDTH_WORK = 16,
    parameter int PRESCALE   = 50,
    parameter int PULSE_W    = 100,
    parameter int DIR_SETUP  = 250,
    parameter int MIN_PERIOD = 20,
    parameter int POS_W      = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  enable,
    input  logic                  dir,
    input  logic [WIDTH_WORK-1:0] N,
    output logic                  drv_step,
    output logic                  drv_dir,
    output logic                  drv_enable,
    output logic                  busy,
    output logic [POS_W-1:0]      position
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_SETUP = 2'd1;
    localparam logic [1:0] S_HI    = 2'd2;
    localparam logic [1:0] S_LO    = 2'd3;

    localparam int CNT_MAX = (DIR_SETUP > PULSE_W) ? DIR_SETUP : PULSE_W;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);
    localparam int PRE_W   = $clog2(PRESCALE + 1);

    localparam logic [CNT_W-1:0]      SETUP_END = CNT_W'(DIR_SETUP);
    localparam logic [CNT_W-1:0]      PULSE_END = CNT_W'(PULSE_W - 1);
    localparam logic [PRE_W-1:0]      PRE_LAST  = PRE_W'(PRESCALE - 1);
    localparam logic [WIDTH_WORK-1:0] MIN_P     = WIDTH_WORK'(MIN_PERIOD);

    logic [1:0]            state;
    logic [CNT_W-1:0]      cnt;
    logic [PRE_W-1:0]      pre;
    logic [WIDTH_WORK-1:0] tick;
    logic [WIDTH_WORK-1:0] p_lat;
    logic [WIDTH_WORK-1:0] n_s1;
    logic [WIDTH_WORK-1:0] n_s2;
    logic [WIDTH_WORK-1:0] n_eff;

    logic [WIDTH_WORK-1:0] p_sel;
    logic [WIDTH_WORK-1:0] tick_last;
    logic                  period_end;
    logic                  go_idle;
    logic                  go_setup;
    logic                  go_hi;
    logic                  go_lo;

    assign p_sel     = (n_eff < MIN_P) ? MIN_P : n_eff;
    assign tick_last = p_lat - 1'b1;

    // Counters start at zero on the rising edge, so the period ends on
    // the edge where (tick, pre) reaches (P-1, PRESCALE-1).
    assign period_end = (pre == PRE_LAST) && (tick == tick_last);

    always_comb begin
        go_idle  = 1'b0;
        go_setup = 1'b0;
        go_hi    = 1'b0;
        go_lo    = 1'b0;
        case (state)
            S_IDLE: begin
                go_setup = enable;
            end
            S_SETUP: begin
                if (!enable) begin
                    go_idle = 1'b1;
                end else if (cnt == SETUP_END) begin
                    go_hi = 1'b1;
                end
            end
            S_HI: begin
                go_lo = (cnt == PULSE_END);
            end
            S_LO: begin
                if (!enable) begin
                    go_idle = 1'b1;
                end else if (period_end) begin
                    if (dir != drv_dir) begin
                        go_setup = 1'b1;
                    end else begin
                        go_hi = 1'b1;
                    end
                end
            end
            default: begin
                go_idle = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= S_IDLE;
            busy       <= 1'b0;
            drv_step   <= 1'b0;
            drv_dir    <= 1'b0;
            drv_enable <= 1'b0;
            position   <= '0;
            cnt        <= '0;
            pre        <= '0;
            tick       <= '0;
            p_lat      <= MIN_P;
            n_s1       <= '0;
            n_s2       <= '0;
            n_eff      <= MIN_P;
        end else begin
            // Two equal consecutive samples filter multi-bit skew on N.
            n_s1 <= N;
            n_s2 <= n_s1;
            if (n_s1 == n_s2) begin
                n_eff <= n_s1;
            end

            if (go_idle) begin
                state      <= S_IDLE;
                busy       <= 1'b0;
                drv_step   <= 1'b0;
                drv_enable <= 1'b0;
            end else if (go_setup) begin
                state      <= S_SETUP;
                busy       <= 1'b1;
                drv_enable <= 1'b1;
                drv_dir    <= dir;
                cnt        <= '0;
                pre        <= '0;
                tick       <= '0;
            end else if (go_hi) begin
                state    <= S_HI;
                busy     <= 1'b1;
                drv_step <= 1'b1;
                p_lat    <= p_sel;
                cnt      <= '0;
                pre      <= '0;
                tick     <= '0;
                if (drv_dir) begin
                    position <= position + 1'b1;
                end else begin
                    position <= position - 1'b1;
                end
            end else begin
                if (state == S_HI || state == S_LO) begin
                    if (pre == PRE_LAST) begin
                        pre  <= '0;
                        tick <= tick + 1'b1;
                    end else begin
                        pre <= pre + 1'b1;
                    end
                end
                if (go_lo) begin
                    state    <= S_LO;
                    drv_step <= 1'b0;
                end else if (state == S_SETUP || state == S_HI) begin
                    cnt <= cnt + 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_step_pulse_gen.sv
// tb_step_pulse_gen: directed timing pins plus randomized run
// against an elapsed-time model of the step generator.
module tb_step_pulse_gen;

    localparam int WW   = 16;
    localparam int PS   = 50;
    localparam int PW   = 100;
    localparam int DS   = 250;
    localparam int MINP = 20;
    localparam int PSW  = 32;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          enable = 1'b0;
    logic          dir = 1'b0;
    logic [WW-1:0] N = '0;
    logic          drv_step;
    logic          drv_dir;
    logic          drv_enable;
    logic          busy;
    logic [PSW-1:0] position;

    step_pulse_gen #(
        .WIDTH_WORK(WW),
        .PRESCALE  (PS),
        .PULSE_W   (PW),
        .DIR_SETUP (DS),
        .MIN_PERIOD(MINP),
        .POS_W     (PSW)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .enable    (enable),
        .dir       (dir),
        .N         (N),
        .drv_step  (drv_step),
        .drv_dir   (drv_dir),
        .drv_enable(drv_enable),
        .busy      (busy),
        .position  (position)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    // Model: mode 0 = off, 1 = waiting out DIR setup, 2 = stepping.
    int             mmode = 0;
    int             t0 = 0;
    int             trise = 0;
    int             mp = MINP;
    logic [WW-1:0]  m_neff = WW'(MINP);
    logic [WW-1:0]  q1 = '0;
    logic [WW-1:0]  q2 = '0;
    logic           m_step = 1'b0;
    logic           m_dir = 1'b0;
    logic           m_en = 1'b0;
    logic           m_busy = 1'b0;
    logic [PSW-1:0] m_pos = '0;

    task do_rise();
        mmode  = 2;
        trise  = cyc;
        mp     = (int'(m_neff) < MINP) ? MINP : int'(m_neff);
        m_step = 1'b1;
        if (m_dir) m_pos = m_pos + 1;
        else       m_pos = m_pos - 1;
    endtask

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            mmode  = 0;
            m_neff = WW'(MINP);
            q1     = '0;
            q2     = '0;
            m_step = 1'b0;
            m_dir  = 1'b0;
            m_en   = 1'b0;
            m_busy = 1'b0;
            m_pos  = '0;
        end else begin
            int k;
            cyc++;
            case (mmode)
                0: if (enable) begin
                    mmode  = 1;
                    t0     = cyc;
                    m_en   = 1'b1;
                    m_busy = 1'b1;
                    m_dir  = dir;
                end
                1: if (!enable) begin
                    mmode  = 0;
                    m_en   = 1'b0;
                    m_busy = 1'b0;
                end else if (cyc - t0 == DS + 1) begin
                    do_rise();
                end
                default: begin
                    k = cyc - trise;
                    if (k == PW) begin
                        m_step = 1'b0;
                    end else if (k > PW) begin
                        if (!enable) begin
                            mmode  = 0;
                            m_en   = 1'b0;
                            m_busy = 1'b0;
                        end else if (k == mp * PS) begin
                            if (dir != m_dir) begin
                                mmode = 1;
                                t0    = cyc;
                                m_dir = dir;
                            end else begin
                                do_rise();
                            end
                        end
                    end
                end
            endcase
            if (q1 == q2) m_neff = q1;
            q2 = q1;
            q1 = N;
        end
    end

    always @(negedge clk) begin
        total++;
        if (drv_step !== m_step || drv_dir !== m_dir ||
            drv_enable !== m_en || busy !== m_busy ||
            position !== m_pos) begin
            bad++;
            $display("FAIL cycle_compare cyc=%0d got step=%b dir=%b en=%b busy=%b pos=%0d want step=%b dir=%b en=%b busy=%b pos=%0d",
                     cyc, drv_step, drv_dir, drv_enable, busy,
                     $signed(position), m_step, m_dir, m_en, m_busy,
                     $signed(m_pos));
        end
    end

    int   rise_cnt = 0;
    int   last_rise = 0;
    int   last_fall = 0;
    int   last_dirfall = 0;
    logic mp_step = 1'b0;
    logic mp_dir = 1'b0;

    always @(posedge clk) begin
        #1;
        if (drv_step && !mp_step) begin
            rise_cnt++;
            last_rise = cyc;
        end
        if (!drv_step && mp_step) last_fall = cyc;
        if (!drv_dir && mp_dir) last_dirfall = cyc;
        mp_step = drv_step;
        mp_dir  = drv_dir;
    end

    task automatic check_int(input string name, input int got, input int exp);
        total++;
        if (got != exp) begin
            bad++;
            $display("FAIL %s got=%0d want=%0d", name, got, exp);
        end
    endtask

    task automatic wait_rise(output int rc);
        int r0;
        int n;
        r0 = rise_cnt;
        n  = 0;
        while (rise_cnt == r0 && n < 20000) begin
            @(negedge clk);
            n++;
        end
        if (rise_cnt == r0) begin
            total++;
            bad++;
            $display("FAIL rise_timeout got=none want=rise by cyc=%0d", cyc);
            rc = cyc;
        end else begin
            rc = last_rise;
        end
    endtask

    task automatic wait_cyc(input int t);
        while (cyc < t) @(negedge clk);
    endtask

    initial begin
        int en_c;
        int r1, r2, r3, r4, r5, r6, r7, r8, r9, r10, r11, r12;
        logic [WW-1:0] n_hold;
        bit glitch;

        N = 16'd100;
        dir = 1'b1;
        repeat (3) @(negedge clk);
        check_int("rst_step", int'(drv_step), 0);
        check_int("rst_dir", int'(drv_dir), 0);
        check_int("rst_enable", int'(drv_enable), 0);
        check_int("rst_busy", int'(busy), 0);
        check_int("rst_pos", $signed(position), 0);
        rst = 1'b1;
        repeat (5) @(negedge clk);

        enable = 1'b1;
        en_c = cyc + 1;
        wait_rise(r1);
        check_int("first_rise_delay", r1 - en_c, 251);
        check_int("pos_1", $signed(position), 1);
        wait_rise(r2);
        check_int("period_n100", r2 - r1, 5000);
        check_int("pulse_width", last_fall - r1, 100);
        check_int("pos_2", $signed(position), 2);

        N = 16'd5;
        wait_rise(r3);
        check_int("period_before_clamp", r3 - r2, 5000);
        check_int("pos_3", $signed(position), 3);
        wait_rise(r4);
        check_int("period_clamp_n5", r4 - r3, 1000);
        N = 16'd0;
        wait_rise(r5);
        wait_rise(r6);
        check_int("period_clamp_n0", r6 - r5, 1000);
        check_int("pulse_width_clamp", last_fall - r5, 100);
        check_int("pos_6", $signed(position), 6);

        wait_cyc(r6 + 300);
        dir = 1'b0;
        wait_rise(r7);
        check_int("dir_change_gap", r7 - r6, 1251);
        check_int("dir_fall_at_end", last_dirfall - r6, 1000);
        check_int("dir_now_low", int'(drv_dir), 0);
        check_int("pos_dec", $signed(position), 5);

        N = 16'd100;
        wait_rise(r8);
        check_int("pos_4", $signed(position), 4);
        wait_cyc(r8 + 200);
        N = 16'd200;
        wait_cyc(r8 + 4997);
        N = 16'd60;
        @(negedge clk);
        N = 16'd200;
        wait_rise(r9);
        check_int("period_current_kept", r9 - r8, 5000);
        wait_rise(r10);
        check_int("period_n200_glitch", r10 - r9, 10000);
        check_int("pos_2b", $signed(position), 2);

        wait_cyc(r10 + 9);
        enable = 1'b0;
        wait_cyc(r10 + 100);
        check_int("hi_untruncated", last_fall - r10, 100);
        check_int("busy_in_lo", int'(busy), 1);
        wait_cyc(r10 + 101);
        check_int("idle_busy", int'(busy), 0);
        check_int("idle_enable", int'(drv_enable), 0);
        check_int("idle_pos", $signed(position), 2);

        N = 16'd100;
        dir = 1'b1;
        repeat (5) @(negedge clk);
        enable = 1'b1;
        en_c = cyc + 1;
        wait_rise(r11);
        check_int("rerun_rise_delay", r11 - en_c, 251);
        check_int("pos_3b", $signed(position), 3);
        wait_cyc(r11 + 5);
        #2;
        rst = 1'b0;
        #1;
        check_int("async_step", int'(drv_step), 0);
        check_int("async_pos", $signed(position), 0);
        check_int("async_enable", int'(drv_enable), 0);
        check_int("async_busy", int'(busy), 0);
        @(negedge clk);
        rst = 1'b1;
        en_c = cyc + 1;
        wait_rise(r12);
        check_int("restart_rise_delay", r12 - en_c, 251);
        check_int("restart_pos", $signed(position), 1);
        check_int("restart_dir", int'(drv_dir), 1);

        n_hold = N;
        glitch = 1'b0;
        for (int i = 0; i < 20000; i++) begin
            @(negedge clk);
            if (glitch) begin
                N = n_hold;
                glitch = 1'b0;
            end else if ($urandom_range(0, 499) == 0) begin
                n_hold = WW'($urandom_range(0, 40));
                N = n_hold;
            end else if ($urandom_range(0, 699) == 0) begin
                N = WW'($urandom_range(0, 255));
                glitch = 1'b1;
            end
            if ($urandom_range(0, 799) == 0) dir = ~dir;
            if ($urandom_range(0, 2999) == 0) enable = ~enable;
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
